// File: rtl/sigma_sparse_pkg.sv
// Shared types and helpers for the SIGMA sparse datapath: encoder FSM states
// plus popcount / count-width functions used by the encoder and controller generator.
package sigma_sparse_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    localparam int POPCOUNT_MAX_W = 64;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int popcount(input logic [POPCOUNT_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/row_compactor.sv
// Combinational per-row analysis: nonzero flags, exclusive prefix counts of
// earlier nonzeros in the row, and the row popcount.
module row_compactor
    import sigma_sparse_pkg::*;
#(
    parameter int COL_SIZE  = 8,
    parameter int DATA_TYPE = 32,
    parameter int CNT_W     = count_width(COL_SIZE)
) (
    input  logic [COL_SIZE-1:0][DATA_TYPE-1:0] row,
    output logic [COL_SIZE-1:0]                nz,
    output logic [COL_SIZE-1:0][CNT_W-1:0]     prefix,
    output logic [CNT_W-1:0]                   pop
);

    logic [CNT_W-1:0]          run;
    logic [POPCOUNT_MAX_W-1:0] nz_ext;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch; blocking '=' is used so the
        // running count updates in loop order.
        run    = '0;
        nz     = '0;
        prefix = '0;
        nz_ext = '0;
        for (int c = 0; c < COL_SIZE; c++) begin
            nz[c]     = (row[c] != '0);
            prefix[c] = run;
            run       = run + CNT_W'(nz[c]);
        end
        nz_ext[COL_SIZE-1:0] = nz;
        pop = CNT_W'(popcount(nz_ext));
    end

endmodule

// File: rtl/bitmap_encoder.sv
// Dense-to-compressed tile encoder: presence bitmap plus packed row-major nonzero buffer.
// Define BITMAP_ENC_CLEAR_EN to zero the nonzero buffer whenever a tile is released.
module bitmap_encoder
    import sigma_sparse_pkg::*;
#(
    parameter int ROW_SIZE       = 4,
    parameter int COL_SIZE       = 8,
    parameter int BUFF_SIZE      = 32,
    parameter int DATA_TYPE      = 32,
    parameter int LOG2_ROW_SIZE  = 2,
    parameter int LOG2_BUFF_SIZE = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [COL_SIZE-1:0][DATA_TYPE-1:0]   in_row,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0]    out_bit_map,
    output logic [BUFF_SIZE-1:0][DATA_TYPE-1:0]  out_nonzero_ele,
    output logic [LOG2_BUFF_SIZE:0]              out_nnz,
    output logic                                 out_overflow
);

    localparam int CW = count_width(COL_SIZE);
    localparam int NW = LOG2_BUFF_SIZE + 1;
    // Wide enough for nnz plus a full row without wrapping, so overflow compares are exact.
    localparam int SW = count_width(BUFF_SIZE + COL_SIZE);

    enc_state_t state, state_next;
    logic [LOG2_ROW_SIZE-1:0] row_cnt;

    logic                          accept, last_row, release_tile;
    logic [COL_SIZE-1:0]           nz;
    logic [COL_SIZE-1:0][CW-1:0]   prefix;
    logic [CW-1:0]                 pop;
    logic [SW-1:0]                 total;
    logic [NW-1:0]                 nnz_next;
    logic                          ovf_hit;
    logic [COL_SIZE-1:0][SW-1:0]   slot_idx;
    logic [COL_SIZE-1:0]           slot_we;

    row_compactor #(
        .COL_SIZE  (COL_SIZE),
        .DATA_TYPE (DATA_TYPE),
        .CNT_W     (CW)
    ) u_row_compactor (
        .row    (in_row),
        .nz     (nz),
        .prefix (prefix),
        .pop    (pop)
    );

    assign in_ready     = (state == FILL);
    assign out_valid    = (state == HOLD);
    assign accept       = in_valid && (state == FILL);
    assign last_row     = (row_cnt == LOG2_ROW_SIZE'(ROW_SIZE - 1));
    assign release_tile = (state == HOLD) && out_ready;

    always_comb begin
        total    = SW'(out_nnz) + SW'(pop);
        ovf_hit  = (total > SW'(BUFF_SIZE));
        nnz_next = ovf_hit ? NW'(BUFF_SIZE) : NW'(total);
        for (int c = 0; c < COL_SIZE; c++) begin
            slot_idx[c] = SW'(out_nnz) + SW'(prefix[c]);
            slot_we[c]  = nz[c] && (slot_idx[c] < SW'(BUFF_SIZE));
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && last_row) state_next = HOLD;
            HOLD:    if (out_ready)          state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the nonzero buffer is reset on purpose: consumers may read
            // slots past out_nnz, and they must never see power-up X.
            row_cnt         <= '0;
            out_bit_map     <= '0;
            out_nonzero_ele <= '0;
            out_nnz         <= '0;
            out_overflow    <= 1'b0;
        end else if (accept) begin
            row_cnt              <= last_row ? '0 : row_cnt + LOG2_ROW_SIZE'(1);
            out_bit_map[row_cnt] <= nz;
            out_nnz              <= nnz_next;
            if (ovf_hit) out_overflow <= 1'b1;
            // Nonzero columns map to distinct slots, so at most one write per slot.
            for (int c = 0; c < COL_SIZE; c++) begin
                if (slot_we[c]) out_nonzero_ele[slot_idx[c][LOG2_BUFF_SIZE-1:0]] <= in_row[c];
            end
        end else if (release_tile) begin
            out_bit_map  <= '0;
            out_nnz      <= '0;
            out_overflow <= 1'b0;
`ifdef BITMAP_ENC_CLEAR_EN
            out_nonzero_ele <= '0;
`else
            // Buffer keeps stale entries; out_nnz bounds valid reads.
`endif
        end
    end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Randomized self-checking bench for bitmap_encoder: a 32-deep and a 16-deep
// instance run in lockstep against a list-based reference model.
module tb_bitmap_encoder;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int DW    = 32;
    localparam int BIG   = 32;
    localparam int SMALL = 16;

    typedef logic [COLS-1:0][DW-1:0] row_t;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    row_t in_row;

    logic                       b_in_ready, b_out_valid, b_ovf;
    logic [ROWS-1:0][COLS-1:0]  b_bm;
    logic [BIG-1:0][DW-1:0]     b_buf;
    logic [5:0]                 b_nnz;

    logic                       s_in_ready, s_out_valid, s_ovf;
    logic [ROWS-1:0][COLS-1:0]  s_bm;
    logic [SMALL-1:0][DW-1:0]   s_buf;
    logic [4:0]                 s_nnz;

    bitmap_encoder dut_big (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (b_in_ready), .in_row (in_row),
        .out_valid (b_out_valid), .out_ready (out_ready),
        .out_bit_map (b_bm), .out_nonzero_ele (b_buf),
        .out_nnz (b_nnz), .out_overflow (b_ovf)
    );

    bitmap_encoder #(.BUFF_SIZE(SMALL), .LOG2_BUFF_SIZE(4)) dut_small (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (s_in_ready), .in_row (in_row),
        .out_valid (s_out_valid), .out_ready (out_ready),
        .out_bit_map (s_bm), .out_nonzero_ele (s_buf),
        .out_nnz (s_nnz), .out_overflow (s_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    row_t                      tile [ROWS];
    logic [DW-1:0]             m_big   [BIG];
    logic [DW-1:0]             m_small [SMALL];
    int                        e_big_nnz, e_small_nnz;
    bit                        e_big_ovf, e_small_ovf;
    logic [ROWS-1:0][COLS-1:0] e_bm;

    task automatic model_reset();
        foreach (m_big[k])   m_big[k]   = '0;
        foreach (m_small[k]) m_small[k] = '0;
        e_big_nnz = 0; e_small_nnz = 0;
        e_big_ovf = 0; e_small_ovf = 0;
        e_bm = '0;
    endtask

    task automatic model_tile();
        logic [DW-1:0] vals[$];
        vals.delete();
        e_bm = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (tile[r][c] != 0) begin
                    e_bm[r][c] = 1'b1;
                    vals.push_back(tile[r][c]);
                end
        e_big_nnz   = (vals.size() > BIG)   ? BIG   : vals.size();
        e_small_nnz = (vals.size() > SMALL) ? SMALL : vals.size();
        e_big_ovf   = vals.size() > BIG;
        e_small_ovf = vals.size() > SMALL;
        for (int k = 0; k < e_big_nnz; k++)   m_big[k]   = vals[k];
        for (int k = 0; k < e_small_nnz; k++) m_small[k] = vals[k];
    endtask

    task automatic model_release();
        e_bm = '0;
        e_big_nnz = 0; e_small_nnz = 0;
        e_big_ovf = 0; e_small_ovf = 0;
`ifdef BITMAP_ENC_CLEAR_EN
        foreach (m_big[k])   m_big[k]   = '0;
        foreach (m_small[k]) m_small[k] = '0;
`endif
    endtask

    task automatic check_outputs(input string tag, input bit valid);
        check({tag, ".b_valid"}, 64'(b_out_valid), 64'(valid));
        check({tag, ".b_ready"}, 64'(b_in_ready),  64'(!valid));
        check({tag, ".s_valid"}, 64'(s_out_valid), 64'(valid));
        check({tag, ".s_ready"}, 64'(s_in_ready),  64'(!valid));
        check({tag, ".b_bitmap"}, 64'(b_bm), 64'(e_bm));
        check({tag, ".s_bitmap"}, 64'(s_bm), 64'(e_bm));
        check({tag, ".b_nnz"}, 64'(b_nnz), 64'(e_big_nnz));
        check({tag, ".s_nnz"}, 64'(s_nnz), 64'(e_small_nnz));
        check({tag, ".b_ovf"}, 64'(b_ovf), 64'(e_big_ovf));
        check({tag, ".s_ovf"}, 64'(s_ovf), 64'(e_small_ovf));
        for (int k = 0; k < BIG; k++)
            check($sformatf("%s.b_buf[%0d]", tag, k), 64'(b_buf[k]), 64'(m_big[k]));
        for (int k = 0; k < SMALL; k++)
            check($sformatf("%s.s_buf[%0d]", tag, k), 64'(s_buf[k]), 64'(m_small[k]));
    endtask

    function automatic row_t random_row();
        row_t row;
        for (int c = 0; c < COLS; c++) row[c] = $urandom;
        return row;
    endfunction

    // Entered and left at a negedge; the first row is driven immediately.
    task automatic send_tile(input string tag, input int hold, input bit gaps);
        for (int r = 0; r < ROWS; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    in_row    = random_row();
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            end
            check({tag, ".fill_ready"}, 64'({b_in_ready, s_in_ready}), 64'(2'b11));
            check({tag, ".fill_valid"}, 64'({b_out_valid, s_out_valid}), 64'(2'b00));
            in_valid  = 1'b1;
            in_row    = tile[r];
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        model_tile();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_outputs({tag, ".done"}, 1'b1);
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_row    = random_row();
            out_ready = 1'b0;
            @(negedge clk);
            check_outputs({tag, ".hold"}, 1'b1);
        end
        out_ready = 1'b1;
        in_valid  = 1'($urandom_range(0, 1));
        in_row    = random_row();
        @(negedge clk);
        model_release();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_outputs({tag, ".release"}, 1'b0);
    endtask

    task automatic load_diagonal();
        for (int r = 0; r < ROWS; r++) begin
            tile[r] = '0;
            tile[r][r] = DW'(32'h10 + r);
        end
    endtask

    initial begin
        int density;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_outputs("reset", 1'b0);

        // Fully dense 1..32 (overflows the 16-deep instance)
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) tile[r][c] = DW'(r * COLS + c + 1);
        send_tile("dense", 0, 1'b0);

        for (int r = 0; r < ROWS; r++) tile[r] = '0;
        send_tile("zero", 0, 1'b0);

        // Diagonal with 5 cycles of backpressure
        load_diagonal();
        send_tile("diag_bp", 5, 1'b0);

        // Reset after two accepted rows discards the partial tile
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1;
            in_row   = random_row();
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs("midreset", 1'b0);
        load_diagonal();
        send_tile("diag_after_rst", 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            density = $urandom_range(0, 100);
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    tile[r][c] = ($urandom_range(0, 99) < density) ? ($urandom | 32'h1) : '0;
            send_tile($sformatf("rand%0d", t), $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitmap_encoder.md
# bitmap_encoder

- Producer-side counterpart of the SIGMA controller generator.
- Takes a dense streaming-matrix tile one row per cycle and emits the compressed form the controller consumes: a `ROW_SIZE x COL_SIZE` presence bitmap plus a packed row-major nonzero buffer.
- One encoder sits in front of each compressed-operand port (input and weight); the tile is held stable until the downstream controller signals it has finished with it.

## Interface

Parameters:
- `ROW_SIZE`, 4: rows per tile.
- `COL_SIZE`, 8: columns per tile (elements per input row).
- `BUFF_SIZE`, 32: nonzero buffer depth.
- `DATA_TYPE`, 32: element width.
- `LOG2_ROW_SIZE`, 2: row counter width.
- `LOG2_BUFF_SIZE`, 5: buffer index width; counts use `LOG2_BUFF_SIZE+1` bits.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: `in_row` holds a valid dense row.
- `in_ready`, out, 1: encoder accepts a row this cycle.
- `in_row[COL_SIZE-1:0]`, in, `DATA_TYPE` each: dense row, column 0 first.
- `out_valid`, out, 1: compressed tile complete and stable.
- `out_ready`, in, 1: consumer releases the tile (driven by done_computing_one_tile).
- `out_bit_map[ROW_SIZE-1:0][COL_SIZE-1:0]`, out, 1 each: presence bit per element.
- `out_nonzero_ele[BUFF_SIZE-1:0]`, out, `DATA_TYPE` each: packed nonzeros, row-major.
- `out_nnz`, out, `LOG2_BUFF_SIZE+1`: number of stored nonzeros.
- `out_overflow`, out, 1: at least one nonzero was dropped.

## Operation

- Two-state FSM: `FILL` and `HOLD`.
  - `in_ready = (state == FILL)`.
  - `out_valid = (state == HOLD)`.
- **Row accept (FILL):** a row is accepted in a cycle where `in_valid && in_ready`. For accepted row `r` (`r` = row counter):
  - `bit_map[r][c] <= (in_row[c] != 0)`.
  - Each nonzero at column `c` is written to index `nnz + prefix(c)`, where `prefix(c)` = count of nonzeros in columns `0..c-1` of the same row.
  - The write happens only if the index is `< BUFF_SIZE`.
  - `nnz <= min(nnz + popcount(row), BUFF_SIZE)`.
  - `overflow` is set (sticky) if `nnz + popcount(row) > BUFF_SIZE`.
  - The bitmap always records the true presence, including dropped elements.
- **Row counter:** increments on each accept. On accepting row `ROW_SIZE-1` the counter wraps to 0 and state goes to `HOLD`.
- **HOLD:**
  - All outputs are frozen; `in_valid` is ignored.
  - On `out_ready`: bitmap, `nnz` and `overflow` clear, and state returns to `FILL`.
- `out_ready` is ignored in `FILL`. `in_valid` with an all-zero row is still a valid accept.

## Timing

- Reset values: state `FILL`, row counter 0, `out_bit_map` all 0, `out_nonzero_ele` all 0, `out_nnz` 0, `out_overflow` 0, `out_valid` 0. `in_ready` is 1 from the first cycle after reset.
- `rst` overrides all activity, including mid-fill or during `HOLD`. A partially filled tile is discarded.
- All outputs are registered. `in_ready` and `out_valid` are decoded from the state register only; there is no combinational path from inputs to outputs.
- **Latency:** the last row accepted in cycle N gives `out_valid = 1` in cycle N+1, with all tile outputs valid in the same cycle.
- **Release:** `out_ready` sampled high in cycle M gives `out_valid = 0` and `in_ready = 1` in cycle M+1. The first row of the next tile can be accepted in M+1.
- Minimum tile period is `ROW_SIZE + 1` cycles.

## Configuration

Macro `BITMAP_ENC_CLEAR_EN`:
- **Defined:** on release in `HOLD`, all `out_nonzero_ele` entries clear to 0, so slots `>= out_nnz` always read 0.
- **Undefined:** buffer entries are not cleared on release. Slots `>= out_nnz` hold stale data from earlier tiles, which saves the clear logic. Consumers use `out_nnz` or the bitmap to bound reads.
- Reset clears the buffer in both builds.

## Structure

- Shared package `sigma_sparse_pkg`:
  - encoder state enum (`FILL`, `HOLD`);
  - `popcount` and count-width functions, also used by the controller generator.
- Sub-module `row_compactor`: purely combinational. Per-column nonzero flags, exclusive prefix counts and row popcount for one `COL_SIZE` row. The encoder adds the running `nnz` and performs the guarded writes.

## Test plan

1. **Fully dense tile:** 4 rows, values 1..32 row-major, `out_ready = 1` -> `out_bit_map` all 1, `out_nonzero_ele[k] = k+1`, `out_nnz = 32`, `out_overflow = 0`, `out_valid` one cycle after the 4th accept.
2. **All-zero tile:** 4 rows of 0 -> bitmap all 0, `out_nnz = 0`, `out_valid` asserted one cycle after the 4th accept.
3. **Diagonal tile:** row `r` has only column `r` = `0x10+r` -> `bit_map[r][r] = 1`, all other bits 0; buffer[0..3] = `0x10..0x13`; `out_nnz = 4`.
4. **Backpressure:** hold `out_ready = 0` for 5 cycles with `in_valid = 1` and changing `in_row` -> `in_ready = 0`, outputs bit-identical throughout. `out_ready` pulse -> `in_ready = 1` next cycle; buffer slots 4..31 read 0 with `BITMAP_ENC_CLEAR_EN` defined.
5. **Overflow:** `BUFF_SIZE = 16`, dense tile of values 1..32 -> `out_nnz = 16`, buffer = 1..16, `out_overflow = 1`, bitmap all 1.
6. **Mid-fill reset:** `rst` after 2 rows accepted, then 4 diagonal rows -> no `out_valid` before the 4th new accept; the result matches scenario 3 exactly.
